// File: rtl/fetch_line_sequencer.sv
// Fetches 16-byte lines in order into a DEPTH-entry FIFO for the pre-decoder, with flush redirect and stale-response drain.
// A pushed line reaches the head one cycle after its response; requests are credit-limited so a push never finds the FIFO full.
module fetch_line_sequencer #(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clkEn,
  input  logic          flush_en,
  input  logic [63:0]   flush_address,
  output logic          icache_req,
  output logic [63:0]   icache_addr,
  input  logic          icache_ready,
  input  logic          icache_resp_valid,
  input  logic [127:0]  icache_resp_data,
  input  logic          pd_advance,
  input  logic          pd_need_next,
  output logic [63:0]   fetchBufferPc,
  output logic [127:0]  fetchBufferInput,
  output logic [127:0]  fetchBufferNext,
  output logic          fetchBufferNextValid,
  output logic          fetchBufferStall
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;

  logic [0:0]    state;
  logic [63:0]   fetch_addr;
  logic [63:0]   tag_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] drop_cnt;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [127:0]  mem_data [DEPTH];
  logic [63:0]   mem_pc   [DEPTH];

  logic [CW:0]   inflight;
  logic [CW-1:0] flush_drop;
  logic [PW-1:0] head_nxt;
  logic          resp_ok;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          has1;
  logic          has2;

  assign inflight   = {1'b0, count} + {1'b0, out_cnt};
  assign resp_ok    = icache_resp_valid && (out_cnt != '0);
  assign flush_drop = out_cnt - CW'(resp_ok);
  assign head_nxt   = head + PW'(1);
  assign has1       = (count != '0);
  assign has2       = (count >= CW'(2));

  assign icache_req  = (state == RUN) && !flush_en && !rst && (inflight < (CW + 1)'(DEPTH));
  assign icache_addr = fetch_addr;
  assign req_fire    = icache_req && icache_ready;

  assign fetchBufferStall     = !has1 || (pd_need_next && !has2) || (state == DRAIN);
  assign fetchBufferNextValid = has2;
  assign fetchBufferPc        = has1 ? mem_pc[head]       : '0;
  assign fetchBufferInput     = has1 ? mem_data[head]     : '0;
  assign fetchBufferNext      = has2 ? mem_data[head_nxt] : '0;

  // Flush overrides every other update in its cycle, including a coincident response.
  assign push = resp_ok && (state == RUN) && !flush_en && !rst;
  assign pop  = pd_advance && has1 && !fetchBufferStall && !flush_en;

  always_ff @(posedge clk) begin
    if (clkEn && push) begin
      mem_data[tail] <= icache_resp_data;
      mem_pc[tail]   <= tag_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (clkEn) begin
      if (rst) begin
        state      <= RUN;
        fetch_addr <= {RESET_PC[63:4], 4'b0};
        tag_pc     <= {RESET_PC[63:4], 4'b0};
        count      <= '0;
        out_cnt    <= '0;
        drop_cnt   <= '0;
        head       <= '0;
        tail       <= '0;
      end else if (flush_en) begin
        // The tag counter restarts at the target: dropped responses never advance it.
        fetch_addr <= flush_address & ~64'hF;
        tag_pc     <= flush_address & ~64'hF;
        count      <= '0;
        head       <= '0;
        tail       <= '0;
        out_cnt    <= flush_drop;
        drop_cnt   <= flush_drop;
        state      <= (flush_drop != '0) ? DRAIN : RUN;
      end else begin
        if (req_fire)
          fetch_addr <= fetch_addr + 64'd16;
        out_cnt <= out_cnt + CW'(req_fire) - CW'(resp_ok);
        if (push) begin
          tail   <= tail + PW'(1);
          tag_pc <= tag_pc + 64'd16;
        end
        if (pop)
          head <= head_nxt;
        if (push && !pop)
          count <= count + CW'(1);
        else if (pop && !push)
          count <= count - CW'(1);
        if (state == DRAIN && resp_ok) begin
          drop_cnt <= drop_cnt - CW'(1);
          if (drop_cnt == CW'(1))
            state <= RUN;
        end
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) (clkEn && push) |-> (count < CW'(DEPTH)));
  a_credit: assert property (@(posedge clk) !rst |-> (inflight <= (CW + 1)'(DEPTH)));

endmodule

// File: tb/tb_fetch_line_sequencer.sv
// Directed bench for fetch_line_sequencer: fill, boundary stall, push+pop, flush drain, flush with response, clock enable.
module tb_fetch_line_sequencer;

  logic         clk = 1'b0;
  logic         rst, clkEn, flush_en;
  logic [63:0]  flush_address;
  logic         icache_req;
  logic [63:0]  icache_addr;
  logic         icache_ready, icache_resp_valid;
  logic [127:0] icache_resp_data;
  logic         pd_advance, pd_need_next;
  logic [63:0]  fetchBufferPc;
  logic [127:0] fetchBufferInput, fetchBufferNext;
  logic         fetchBufferNextValid, fetchBufferStall;

  int tests = 0;
  int fails = 0;

  logic [127:0] l0, l1, l2, l3, l4, stale, junk;

  fetch_line_sequencer #(.DEPTH(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .flush_en(flush_en), .flush_address(flush_address),
    .icache_req(icache_req), .icache_addr(icache_addr), .icache_ready(icache_ready),
    .icache_resp_valid(icache_resp_valid), .icache_resp_data(icache_resp_data),
    .pd_advance(pd_advance), .pd_need_next(pd_need_next),
    .fetchBufferPc(fetchBufferPc), .fetchBufferInput(fetchBufferInput),
    .fetchBufferNext(fetchBufferNext), .fetchBufferNextValid(fetchBufferNextValid),
    .fetchBufferStall(fetchBufferStall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge, then drive the given inputs and let combinational outputs settle.
  task automatic cyc(input logic rdy, input logic rv, input logic [127:0] rd,
                     input logic adv, input logic nn);
    @(posedge clk);
    #1;
    icache_ready      = rdy;
    icache_resp_valid = rv;
    icache_resp_data  = rd;
    pd_advance        = adv;
    pd_need_next      = nn;
    #1;
  endtask

  initial begin
    l0    = 128'h000102030405060708090a0b0c0d0e0f;
    l1    = 128'h101112131415161718191a1b1c1d1e1f;
    l2    = 128'h202122232425262728292a2b2c2d2e2f;
    l3    = 128'h303132333435363738393a3b3c3d3e3f;
    l4    = 128'h404142434445464748494a4b4c4d4e4f;
    stale = 128'hdeaddeaddeaddeaddeaddeaddeaddead;
    junk  = 128'hbadbadbadbadbadbadbadbadbadbadba;

    rst = 1'b1; clkEn = 1'b1; flush_en = 1'b0; flush_address = '0;
    icache_ready = 1'b1; icache_resp_valid = 1'b0; icache_resp_data = '0;
    pd_advance = 1'b0; pd_need_next = 1'b0;
    #1;
    check("req_in_reset", icache_req, 0);

    @(posedge clk); #1;
    rst = 1'b0; icache_ready = 1'b0; #1;
    check("rst_stall", fetchBufferStall, 1);
    check("rst_nextvalid", fetchBufferNextValid, 0);
    check("rst_pc", fetchBufferPc, 0);
    check("rst_input", fetchBufferInput, 0);
    check("rst_addr", icache_addr, 0);

    // Cycle A: first request at 0x0
    icache_ready = 1'b1; #1;
    check("reqA", icache_req, 1);
    check("addrA", icache_addr, 64'h0);
    cyc(1'b1, 1'b1, l0, 1'b0, 1'b0);            // B: request 0x10, response line@0x0
    check("addrB", icache_addr, 64'h10);
    check("stall_before_first", fetchBufferStall, 1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);            // C: one line held
    check("stall_one_line", fetchBufferStall, 0);
    check("pc_first", fetchBufferPc, 64'h0);
    check("input_first", fetchBufferInput, l0);
    pd_need_next = 1'b1; #1;
    check("stall_need_next", fetchBufferStall, 1);
    check("nextvalid_one", fetchBufferNextValid, 0);
    cyc(1'b1, 1'b1, l1, 1'b0, 1'b1);            // D: request 0x20, response line@0x10
    check("addrD", icache_addr, 64'h20);
    cyc(1'b1, 1'b1, l2, 1'b1, 1'b1);            // E: push line@0x20 and pop together
    check("stall_two_lines", fetchBufferStall, 0);
    check("nextvalid_two", fetchBufferNextValid, 1);
    check("next_line", fetchBufferNext, l1);
    check("addrE", icache_addr, 64'h30);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);            // F
    check("pc_after_pushpop", fetchBufferPc, 64'h10);
    check("input_after_pushpop", fetchBufferInput, l1);
    check("nextvalid_kept", fetchBufferNextValid, 1);
    check("next_after_pushpop", fetchBufferNext, l2);
    check("addrF", icache_addr, 64'h40);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);            // G: count 2 + out 2 = DEPTH
    check("req_credit_full", icache_req, 0);
    check("addr_hold", icache_addr, 64'h50);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);            // H: credit freed by pop
    check("pc_third", fetchBufferPc, 64'h20);
    check("req_after_pop", icache_req, 1);

    // Flush with three outstanding and no response this cycle
    @(posedge clk); #1;
    pd_advance = 1'b0; icache_ready = 1'b1;
    flush_en = 1'b1; flush_address = 64'h1234; #1;
    check("req_during_flush", icache_req, 0);
    @(posedge clk); #1;
    flush_en = 1'b0; #1;
    check("drain_stall", fetchBufferStall, 1);
    check("drain_addr", icache_addr, 64'h1230);
    cyc(1'b1, 1'b1, junk, 1'b0, 1'b0);
    check("drain_req1", icache_req, 0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, junk, 1'b0, 1'b0);
    check("drain_req2", icache_req, 0);
    cyc(1'b1, 1'b1, junk, 1'b0, 1'b0);
    check("drain_req3", icache_req, 0);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("redirect_req", icache_req, 1);
    check("redirect_addr", icache_addr, 64'h1230);
    check("redirect_empty_pc", fetchBufferPc, 0);
    cyc(1'b0, 1'b1, l3, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("redirect_pc", fetchBufferPc, 64'h1230);
    check("redirect_input", fetchBufferInput, l3);
    check("redirect_stall", fetchBufferStall, 0);

    // Flush coinciding with the only outstanding response
    icache_ready = 1'b1; #1;
    check("addr_pre_flush2", icache_addr, 64'h1240);
    @(posedge clk); #1;
    flush_en = 1'b1; flush_address = 64'h5678;
    icache_resp_valid = 1'b1; icache_resp_data = stale; #1;
    @(posedge clk); #1;
    flush_en = 1'b0; icache_resp_valid = 1'b0; icache_resp_data = '0; #1;
    check("flush2_req", icache_req, 1);
    check("flush2_addr", icache_addr, 64'h5670);
    check("flush2_empty", fetchBufferStall, 1);
    check("flush2_nextvalid", fetchBufferNextValid, 0);
    cyc(1'b0, 1'b1, l4, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("flush2_pc", fetchBufferPc, 64'h5670);
    check("flush2_input", fetchBufferInput, l4);

    // Clock enable low: state frozen, reset ignored
    clkEn = 1'b0; icache_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      rst = (i >= 3);
      #1;
    end
    check("gated_req_rst", icache_req, 0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("gated_addr", icache_addr, 64'h5680);
    check("gated_pc", fetchBufferPc, 64'h5670);
    check("gated_req", icache_req, 1);
    clkEn = 1'b1;
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    check("post_gate_addr", icache_addr, 64'h56b0);
    check("post_gate_credit", icache_req, 0);
    check("post_gate_pc", fetchBufferPc, 64'h5670);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_line_sequencer.md
Name: fetch_line_sequencer

Overview:
- Front-end controller between the I-cache and the pre-decoder.
- Issues 16-byte-aligned line fetches and buffers the returned lines in order in a small FIFO.
- Presents the head line (and the following line, for instructions that cross a boundary) to the pre-decoder, and raises the fetch-buffer stall while the needed bytes are absent.
- Handles flush redirects, including discarding stale in-flight responses.

Parameters:
DEPTH, 4, number of 128-bit line entries in the FIFO (power of 2, >=2)
RESET_PC, 64'h0, fetch address after reset (low 4 bits ignored)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset, effective only when clkEn=1
clkEn  input  1  global clock enable; all state updates gated by it
flush_en  input  1  redirect request
flush_address  input  64  redirect target PC
icache_req  output  1  line fetch request
icache_addr  output  64  line address, bits [3:0] always 0
icache_ready  input  1  I-cache accepts the request this cycle
icache_resp_valid  input  1  line data valid (responses return in request order)
icache_resp_data  input  128  line data, byte 0 in bits [7:0]
pd_advance  input  1  pre-decoder has consumed the head line
pd_need_next  input  1  current or next instruction crosses into the following line
fetchBufferPc  output  64  PC of the head line (16-aligned)
fetchBufferInput  output  128  head line data
fetchBufferNext  output  128  line after the head (valid only when fetchBufferNextValid=1)
fetchBufferNextValid  output  1  FIFO holds at least 2 lines
fetchBufferStall  output  1  pre-decoder must hold

Behaviour:
- Storage: FIFO of {data[127:0], pc[63:0]}, with head/tail pointers and count 0..DEPTH.
- Outstanding counter out_cnt, 0..DEPTH. Credit rule: count + out_cnt <= DEPTH always, so a push never finds the FIFO full (assert this).
- FSM states: RUN, DRAIN.
- Reset (rst && clkEn): state=RUN, fetch_addr={RESET_PC[63:4],4'b0}, count=0, out_cnt=0, drop_cnt=0, pointers=0.
  - Resulting outputs: icache_req=0 during the reset cycle; fetchBufferStall=1, fetchBufferNextValid=0, fetchBufferPc=0, fetchBufferInput=0.
- icache_req (combinational) = state==RUN && !flush_en && !rst && (count+out_cnt)<DEPTH.
- icache_addr = fetch_addr.
- Request handshake: icache_req && icache_ready → fetch_addr += 16 (64-bit wrap), out_cnt += 1.
- Response in RUN: push {icache_resp_data, pc}, out_cnt -= 1.
  - pc comes from a separate in-order PC tag counter: the address of the oldest outstanding request.
- Response in DRAIN: discard the data, out_cnt -= 1, drop_cnt -= 1. When drop_cnt reaches 0 (the drop_cnt==1 cycle with a response), go to RUN.
- Pop: pd_advance && count>0 && !fetchBufferStall → head advances. pd_advance with count==0 is ignored.
- Simultaneous push and pop: count unchanged, data ordering preserved. A push into an empty FIFO is visible at the head the next cycle; there is no bypass.
- fetchBufferStall (combinational) = count==0 || (pd_need_next && count<2) || state==DRAIN.
- Flush (flush_en && clkEn, not rst; priority over request, response and pop in that cycle):
  - count=0; fetch_addr = flush_address & ~64'hF.
  - drop_cnt = out_cnt − (icache_resp_valid ? 1 : 0).
  - Next state = DRAIN if drop_cnt != 0, else RUN.
  - A response arriving in the flush cycle is discarded.
- Flush while in DRAIN: recompute drop_cnt with the same rule; remain in or leave DRAIN accordingly.
- Reset mid-DRAIN: all counters cleared. Any in-flight I-cache response after reset is the I-cache's responsibility; the I-cache is reset together with this block.
- clkEn=0: all registers hold; combinational outputs still follow inputs.
- Widths: count, out_cnt and drop_cnt are $clog2(DEPTH+1) bits.

Test Plan:
- Reset, then icache_ready=1 and single-cycle responses → requests go out at 0x0, 0x10, 0x20, 0x30, then icache_req drops (count+out_cnt=4). fetchBufferStall deasserts one cycle after the first response. fetchBufferPc=0x0.
- FIFO holds 1 line, pd_need_next=1 → fetchBufferStall=1 until the second line arrives. Then fetchBufferNextValid=1 and fetchBufferNext=line@0x10.
- Push and pd_advance in the same cycle with count=2 → count stays 2; head PC advances 0x0→0x10.
- out_cnt=3, flush_en with flush_address=0x1234 and no response that cycle → DRAIN with drop_cnt=3. Three responses are discarded, then icache_addr=0x1230 is requested. First valid head PC=0x1230.
- Flush coinciding with icache_resp_valid and out_cnt=1 → drop_cnt=0, state=RUN, no stale data pushed, next request at the aligned target.
- clkEn=0 for 5 cycles with icache_ready=1 → fetch_addr, count and out_cnt unchanged. rst asserted while clkEn=0 has no effect.
